// File: rtl/msx_mouse_pkg.sv
// Shared types and constants for the MSX mouse port: nibble-state enum, saturation limit,
// default strobe timeout and the saturating clamp used by both axis accumulators.
package msx_mouse_pkg;

  typedef enum logic [1:0] {
    S_XH = 2'd0,
    S_XL = 2'd1,
    S_YH = 2'd2,
    S_YL = 2'd3
  } nib_state_t;

  localparam int SAT_MAX         = 127;
  localparam int DEF_TIMEOUT_CYC = 100000;

  // Clamp a 10-bit signed sum into the symmetric range [-SAT_MAX, +SAT_MAX].
  function automatic logic [7:0] sat8(input logic signed [9:0] v);
    logic signed [9:0] lim;
    lim = 10'(SAT_MAX);
    if (v > lim)       return 8'(SAT_MAX);
    else if (v < -lim) return 8'(-SAT_MAX);
    else               return v[7:0];
  endfunction

endpackage

// File: rtl/msx_mouse_accum.sv
// One-axis signed 8-bit motion accumulator with saturation; clr zeroes the running value and a
// same-cycle add lands on the cleared value. Build option: MSX_MOUSE_ACCUM_EN (accumulate vs overwrite).
module msx_mouse_accum
  import msx_mouse_pkg::*;
(
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       add_en,
  input  logic       clr,
  input  logic [8:0] delta,
  output logic [7:0] acc
);

  logic [7:0]        acc_q, acc_d;
  logic signed [9:0] sum;

  always_comb begin
`ifdef MSX_MOUSE_ACCUM_EN
    sum = (clr ? 10'sd0 : $signed({{2{acc_q[7]}}, acc_q})) + $signed({delta[8], delta});
`else
    sum = $signed({delta[8], delta});
`endif
    acc_d = acc_q;
    if (add_en)   acc_d = sat8(sum);
    else if (clr) acc_d = 8'h00;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) acc_q <= 8'h00;
    else       acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/msx_mouse_port.sv
// MSX joystick-port mouse emulation: PS/2 deltas are accumulated and shifted out as four nibbles
// clocked by msx_str edges; falls back to the physical joystick when it is touched. Option: MSX_MOUSE_ACCUM_EN.
module msx_mouse_port
  import msx_mouse_pkg::*;
#(
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ms_strobe,
  input  logic [8:0] ms_dx,
  input  logic [8:0] ms_dy,
  input  logic [1:0] ms_btn,
  input  logic [5:0] joy_in,
  input  logic       msx_str,
  output logic [5:0] port_out,
  output logic       mouse_active
);

  localparam int            CW      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TO_LOAD = CW'(TIMEOUT_CYC);

  nib_state_t    state_q, state_d;
  logic          active_q, active_d;
  logic          str_q;
  logic [7:0]    tx_x_q, tx_x_d, tx_y_q, tx_y_d;
  logic [3:0]    nib_q, nib_d;
  logic [1:0]    btn_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_q;
  logic [8:0]    dx_q, dy_q;

  logic       str_edge, fall, snap, acc_clr, acc_add;
  logic [7:0] acc_x, acc_y, neg_x, neg_y;

  assign str_edge = msx_str ^ str_q;
  assign neg_x    = 8'h00 - acc_x;
  assign neg_y    = 8'h00 - acc_y;

  always_comb begin
    active_d = ms_strobe ? 1'b1 : ((&joy_in) ? active_q : 1'b0);
    fall     = active_q & ~active_d;
    snap     = str_edge & (state_q == S_XH) & ~fall;
    acc_clr  = snap | fall;
    // A delta registered last cycle is dropped only when mouse mode is being abandoned.
    acc_add  = pend_q & ~fall;

    state_d = state_q;
    tx_x_d  = tx_x_q;
    tx_y_d  = tx_y_q;
    nib_d   = nib_q;
    cnt_d   = (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
    if (str_edge) cnt_d = TO_LOAD;

    if (fall) begin
      state_d = S_XH;
      tx_x_d  = 8'h00;
      tx_y_d  = 8'h00;
    end else if (str_edge) begin
      case (state_q)
        S_XH: begin
          tx_x_d  = neg_x;
          tx_y_d  = neg_y;
          nib_d   = neg_x[7:4];
          state_d = S_XL;
        end
        S_XL: begin
          nib_d   = tx_x_q[3:0];
          state_d = S_YH;
        end
        S_YH: begin
          nib_d   = tx_y_q[7:4];
          state_d = S_YL;
        end
        default: begin
          nib_d   = tx_y_q[3:0];
          state_d = S_XH;
        end
      endcase
    end else if (cnt_q == CW'(1)) begin
      state_d = S_XH;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q  <= S_XH;
      active_q <= 1'b0;
      str_q    <= msx_str;
      tx_x_q   <= 8'h00;
      tx_y_q   <= 8'h00;
      nib_q    <= 4'h0;
      btn_q    <= 2'b11;
      cnt_q    <= '0;
      pend_q   <= 1'b0;
      dx_q     <= 9'h000;
      dy_q     <= 9'h000;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      str_q    <= msx_str;
      tx_x_q   <= tx_x_d;
      tx_y_q   <= tx_y_d;
      nib_q    <= nib_d;
      btn_q    <= ~ms_btn;
      cnt_q    <= cnt_d;
      pend_q   <= ms_strobe;
      dx_q     <= ms_dx;
      dy_q     <= ms_dy;
    end
  end

  msx_mouse_accum u_acc_x (
    .clk_sys (clk_sys),
    .reset   (reset),
    .add_en  (acc_add),
    .clr     (acc_clr),
    .delta   (dx_q),
    .acc     (acc_x)
  );

  msx_mouse_accum u_acc_y (
    .clk_sys (clk_sys),
    .reset   (reset),
    .add_en  (acc_add),
    .clr     (acc_clr),
    .delta   (dy_q),
    .acc     (acc_y)
  );

  assign port_out     = active_q ? {btn_q, nib_q[0], nib_q[1], nib_q[2], nib_q[3]} : joy_in;
  assign mouse_active = active_q;

endmodule

// File: doc/msx_mouse_port.md
MSX_MOUSE_PORT -- requirements
Module: msx_mouse_port

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 100000: idle clk_sys cycles after the last msx_str edge before the nibble sequence restarts at the X-high nibble.
REQ-002 SHALL have port `clk_sys  in  1`: system clock; all logic is on its rising edge.
REQ-003 SHALL have port `reset  in  1`: synchronous, active-high reset.
REQ-004 SHALL have port `ms_strobe  in  1`: one-cycle pulse marking a new PS/2 mouse packet.
REQ-005 SHALL have port `ms_dx  in  9`: signed two's-complement X delta, positive = right; valid while ms_strobe=1.
REQ-006 SHALL have port `ms_dy  in  9`: signed two's-complement Y delta, positive = up; valid while ms_strobe=1.
REQ-007 SHALL have port `ms_btn  in  2`: mouse buttons, active-high; [0] = left, [1] = right.
REQ-008 SHALL have port `joy_in  in  6`: physical joystick, active-low.
REQ-009 SHALL have port `msx_str  in  1`: MSX joystick-port strobe from the core, already in the clk_sys domain.
REQ-010 SHALL have port `port_out  out  6`: active-low port value to the MSX core; [5:4] = buttons, [3:0] = data.
REQ-011 SHALL have port `mouse_active  out  1`: high while the port is in mouse mode.

Function
REQ-012 SHALL hold two signed 8-bit accumulators, acc_x and acc_y; each new delta is added with saturation to [-127,+127].
REQ-013 SHALL include each ms_strobe delta into the accumulators on the cycle after the strobe.
REQ-014 SHALL keep a 2-bit nibble state with values S_XH, S_XL, S_YH, S_YL; it resets to S_XH.
REQ-015 SHALL compare msx_str with a registered copy str_d each cycle; any difference is an edge.
REQ-016 SHALL, on an edge in S_XH, snapshot tx_x = -acc_x and tx_y = -acc_y, then clear both accumulators.
REQ-017 SHALL, if ms_strobe coincides with the S_XH edge, leave the new delta in the cleared accumulator so it is neither lost nor part of the snapshot.
REQ-018 SHALL, on each edge, register the nibble for the current state (tx_x[7:4], tx_x[3:0], tx_y[7:4], tx_y[3:0] in state order) and advance the state, wrapping S_YL to S_XH; port_out shows the nibble one cycle after the edge.
REQ-019 SHALL present each nibble n bit-reversed: port_out[3]=n[0], port_out[2]=n[1], port_out[1]=n[2], port_out[0]=n[3].
REQ-020 SHALL drive port_out[5:4] = ~ms_btn[1:0], registered every cycle.
REQ-021 SHALL reload a timeout counter to TIMEOUT_CYC on each edge and decrement it while nonzero.
REQ-022 SHALL force the state to S_XH when the timeout counter reaches 1; an edge in that same cycle takes priority.
REQ-023 SHALL set mouse_active on ms_strobe, and clear it when any joy_in bit is 0 with no ms_strobe in that cycle (strobe wins).
REQ-024 SHALL drive port_out = joy_in combinationally while mouse_active=0.
REQ-025 SHALL, when mouse_active falls, set the state to S_XH and clear the accumulators and tx registers.

Reset
REQ-026 SHALL, under reset, set mouse_active=0, state=S_XH, acc_x=acc_y=0, tx_x=tx_y=0, data nibble register=4'h0, timeout counter=0, str_d=msx_str; port_out therefore equals joy_in.
REQ-027 SHALL give reset priority over ms_strobe, edges and timeout, so reset in mid-sequence restarts at S_XH.

Configuration
REQ-028 SHALL, with macro MSX_MOUSE_ACCUM_EN defined, accumulate deltas with saturation as in REQ-012.
REQ-029 SHALL, without MSX_MOUSE_ACCUM_EN, overwrite each accumulator with the saturated new delta on every strobe; all other behaviour is unchanged.

Structure
REQ-030 SHALL define in package msx_mouse_pkg: the nibble-state enum, the constant SAT_MAX=127, and the default TIMEOUT_CYC.
REQ-031 SHALL implement the saturating accumulator as sub-module msx_mouse_accum, instanced once per axis, with inputs add_en, clr and delta[8:0] and output acc[7:0].

Verification
REQ-032 SHALL check: reset with joy_in=6'h3F -> port_out=6'h3F, mouse_active=0.
REQ-033 SHALL check: ms_strobe with dx=+5, dy=-3, ms_btn=0, then 4 msx_str toggles -> port_out[3:0] = F, D, 0, C and port_out[5:4]=2'b11.
REQ-034 SHALL check: three strobes with dx=+100 and MSX_MOUSE_ACCUM_EN defined -> acc_x=127 and X nibbles 1, 8; without the macro -> acc_x=100.
REQ-035 SHALL check: 2 toggles, then TIMEOUT_CYC idle cycles, then 1 toggle -> X-high nibble of a fresh snapshot.
REQ-036 SHALL check: mouse active and joy_in=6'h3E -> mouse_active=0 next cycle and port_out=6'h3E; the same input with ms_strobe in that cycle -> mouse_active stays 1.
REQ-037 SHALL check: ms_strobe (dx=+2) in the same cycle as an S_XH edge -> current sequence excludes +2; next sequence X = -2 (nibbles F, 7).
